// File: rtl/lut_sweep_checker_pkg.sv
// Shared types and helpers for the on-chip exhaustive truth-table sweep checker.
package lut_sweep_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Number of vectors swept for an N-input DUT.
    function automatic int unsigned vec_count(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    // Settle counter width; at least one bit even when SETTLE is 1.
    function automatic int unsigned settle_width(input int unsigned settle);
        return (settle > 32'd1) ? $clog2(settle) : 32'd1;
    endfunction

endpackage

// File: rtl/lut_sweep_checker.sv
// Sweeps every input vector into a same-clock combinational DUT, captures its
// truth table and compares it against an expected mask latched at start.
module lut_sweep_checker
    import lut_sweep_checker_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [(1<<N_IN)-1:0]     expected,
    output logic [N_IN-1:0]          stim,
    input  logic                     resp,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [(1<<N_IN)-1:0]     captured,
    output logic [N_IN:0]            mismatches,
    output logic [N_IN-1:0]          first_fail_idx,
    output logic                     first_fail_valid
);

    localparam int unsigned NV = vec_count(N_IN);
    localparam int unsigned CW = settle_width(SETTLE);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [NV-1:0]      r_exp;
    logic [N_IN-1:0]    r_stim;
    logic [NV-1:0]      r_captured;
    logic [N_IN:0]      r_mism;
    logic [N_IN-1:0]    r_ffi;
    logic               r_ffv;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               w_last;
    logic               w_settled;
    logic               w_miss;
    logic [N_IN:0]      w_mism_nxt;

    // Decode conditions and the next FSM state.
    always_comb begin
        w_state_nxt = r_state;
        w_last      = (r_stim == {N_IN{1'b1}});
        w_settled   = (r_cnt == CW'(SETTLE - 1));
        w_miss      = resp ^ r_exp[r_stim];
        w_mism_nxt  = r_mism + {{N_IN{1'b0}}, w_miss};
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_DRIVE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (w_settled) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stimulus, settle counter and result registers; pass/done are set on the
    // final sample edge so they are valid in the single DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_exp      <= '0;
            r_stim     <= '0;
            r_captured <= '0;
            r_mism     <= '0;
            r_ffi      <= '0;
            r_ffv      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_exp      <= expected;
                        r_captured <= '0;
                        r_mism     <= '0;
                        r_ffi      <= '0;
                        r_ffv      <= 1'b0;
                        r_stim     <= '0;
                        r_cnt      <= '0;
                        r_pass     <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (w_settled) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_SAMPLE: begin
                    r_captured[r_stim] <= resp;
                    r_mism             <= w_mism_nxt;
                    if (w_miss && !r_ffv) begin
                        r_ffi <= r_stim;
                        r_ffv <= 1'b1;
                    end
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_mism_nxt == '0);
                    end else begin
                        r_stim <= r_stim + N_IN'(1);
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign stim             = r_stim;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign captured         = r_captured;
    assign mismatches       = r_mism;
    assign first_fail_idx   = r_ffi;
    assign first_fail_valid = r_ffv;

endmodule

// File: tb/tb_lut_sweep_checker.sv
// Directed bench for lut_sweep_checker: parity, constant and delayed-parity
// DUT models, restart/expected-change immunity and mid-sweep reset.
module tb_lut_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sel;
    logic [15:0] expected;
    int          mode;

    logic [3:0]  stim0, stim1, ffi0, ffi1;
    logic        resp0, resp1, busy0, busy1, done0, done1, pass0, pass1;
    logic        ffv0, ffv1, r_par0, r_par1;
    logic [15:0] cap0, cap1;
    logic [4:0]  mism0, mism1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lut_sweep_checker #(.N_IN(4), .SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .expected(expected),
        .stim(stim0), .resp(resp0), .busy(busy0), .done(done0), .pass(pass0),
        .captured(cap0), .mismatches(mism0), .first_fail_idx(ffi0),
        .first_fail_valid(ffv0)
    );

    lut_sweep_checker #(.N_IN(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .expected(expected),
        .stim(stim1), .resp(resp1), .busy(busy1), .done(done1), .pass(pass1),
        .captured(cap1), .mismatches(mism1), .first_fail_idx(ffi1),
        .first_fail_valid(ffv1)
    );

    // Registered-parity DUT models (one cycle of latency).
    always @(posedge clk) begin
        r_par0 <= ^stim0;
        r_par1 <= ^stim1;
    end

    // Response model selection for the SETTLE=2 instance.
    always_comb begin
        case (mode)
            0:       resp0 = ^stim0;
            1:       resp0 = 1'b0;
            2:       resp0 = r_par0;
            default: resp0 = 1'b0;
        endcase
    end
    assign resp1 = r_par1;

    wire        done_m = sel ? done1 : done0;
    wire        busy_m = sel ? busy1 : busy0;
    wire        pass_m = sel ? pass1 : pass0;
    wire [15:0] cap_m  = sel ? cap1  : cap0;
    wire [4:0]  mism_m = sel ? mism1 : mism0;
    wire [3:0]  ffi_m  = sel ? ffi1  : ffi0;
    wire        ffv_m  = sel ? ffv1  : ffv0;
    wire [3:0]  stim_m = sel ? stim1 : stim0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulses start with the given mask and returns done latency in cycles.
    // Optional re-start at k=10 with expected change at k=12, or reset at rst_at.
    task automatic sweep(input logic [15:0] exp, input bit restart,
                         input int rst_at, output int lat);
        int k;
        @(negedge clk);
        expected = exp;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k     = 1;
        chk("busy_rise", {31'd0, busy_m}, 32'd1);
        while (!done_m && k < 200) begin
            @(negedge clk);
            k++;
            if (restart && k == 10) start = 1'b1;
            if (restart && k == 11) start = 1'b0;
            if (restart && k == 12) expected = 16'h0000;
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                lat = k;
                return;
            end
        end
        lat = k;
    endtask

    initial begin
        int lat;
        rst_n    = 1'b0;
        start    = 1'b0;
        sel      = 1'b0;
        mode     = 0;
        expected = 16'h0000;
        #12;
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_cap",  {16'd0, cap0},  32'd0);
        chk("rst_mism", {27'd0, mism0}, 32'd0);
        chk("rst_stim", {28'd0, stim0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: combinational parity, matching mask
        sweep(16'h6996, 1'b0, 0, lat);
        chk("s1_lat",  lat, 32'd49);
        chk("s1_pass", {31'd0, pass_m}, 32'd1);
        chk("s1_cap",  {16'd0, cap_m}, 32'h6996);
        chk("s1_mism", {27'd0, mism_m}, 32'd0);
        chk("s1_ffv",  {31'd0, ffv_m}, 32'd0);
        chk("s1_busy", {31'd0, busy_m}, 32'd0);
        @(negedge clk);
        chk("s1_pulse", {31'd0, done_m}, 32'd0);
        chk("s1_hold_pass", {31'd0, pass_m}, 32'd1);
        chk("s1_stim_hold", {28'd0, stim_m}, 32'd15);

        // 2: one wrong expected bit at index 0
        sweep(16'h6997, 1'b0, 0, lat);
        chk("s2_lat",  lat, 32'd49);
        chk("s2_pass", {31'd0, pass_m}, 32'd0);
        chk("s2_mism", {27'd0, mism_m}, 32'd1);
        chk("s2_ffi",  {28'd0, ffi_m}, 32'd0);
        chk("s2_ffv",  {31'd0, ffv_m}, 32'd1);
        chk("s2_cap",  {16'd0, cap_m}, 32'h6996);

        // 2b: wrong bits at indices 5 and 8
        sweep(16'h6996 ^ 16'h0120, 1'b0, 0, lat);
        chk("s2b_mism", {27'd0, mism_m}, 32'd2);
        chk("s2b_ffi",  {28'd0, ffi_m}, 32'd5);
        chk("s2b_pass", {31'd0, pass_m}, 32'd0);

        // 3: resp stuck at 0 against all-ones mask
        mode = 1;
        sweep(16'hFFFF, 1'b0, 0, lat);
        chk("s3_mism", {27'd0, mism_m}, 32'd16);
        chk("s3_ffi",  {28'd0, ffi_m}, 32'd0);
        chk("s3_cap",  {16'd0, cap_m}, 32'h0000);
        chk("s3_pass", {31'd0, pass_m}, 32'd0);

        // 4: start re-pulse and expected change mid-sweep are ignored
        mode = 0;
        sweep(16'h6996, 1'b1, 0, lat);
        chk("s4_lat",  lat, 32'd49);
        chk("s4_pass", {31'd0, pass_m}, 32'd1);
        chk("s4_cap",  {16'd0, cap_m}, 32'h6996);
        chk("s4_mism", {27'd0, mism_m}, 32'd0);

        // 5: reset mid-sweep aborts, then a full sweep runs
        sweep(16'h6996, 1'b0, 20, lat);
        chk("s5_busy", {31'd0, busy_m}, 32'd0);
        chk("s5_stim", {28'd0, stim_m}, 32'd0);
        chk("s5_cap",  {16'd0, cap_m}, 32'd0);
        chk("s5_mism", {27'd0, mism_m}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(16'h6996, 1'b0, 0, lat);
        chk("s5_lat",  lat, 32'd49);
        chk("s5_pass", {31'd0, pass_m}, 32'd1);

        // 6: registered parity DUT with SETTLE=2 and SETTLE=1
        mode = 2;
        sweep(16'h6996, 1'b0, 0, lat);
        chk("s6_lat2",  lat, 32'd49);
        chk("s6_pass2", {31'd0, pass_m}, 32'd1);
        sel = 1'b1;
        sweep(16'h6996, 1'b0, 0, lat);
        chk("s6_lat1",  lat, 32'd33);
        chk("s6_pass1", {31'd0, pass_m}, 32'd1);
        chk("s6_cap1",  {16'd0, cap_m}, 32'h6996);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lut_sweep_checker.md
Name: lut_sweep_checker

Overview:
- Hardware counterpart of the exhaustive combinational testbench flow: drives every input combination into a combinational DUT (e.g. `lut`) and reads back its output.
- Captures the DUT truth table, compares it against an expected mask, and reports pass/fail, mismatch count and first failing index.
- Sits on-chip between a control source (buttons/UART/host logic) and the DUT, replacing the simulation-only file dump with a synthesizable result register.

Parameters:
- N_IN, 4, number of DUT inputs; vectors swept = 2**N_IN.
- SETTLE, 2, cycles each vector is held before sampling; must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- expected  input  2**N_IN  expected truth table; bit i = F for stim == i.
- stim  output  N_IN  vector driven to the DUT inputs (MSB = first DUT input, e.g. {A,B,C,D}).
- resp  input  1  DUT output F.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when results become valid.
- pass  output  1  1 iff mismatches == 0; valid from done until the next start.
- captured  output  2**N_IN  sampled DUT truth table.
- mismatches  output  N_IN+1  count of differing vectors (0..2**N_IN).
- first_fail_idx  output  N_IN  lowest failing vector index; 0 if none.
- first_fail_valid  output  1  at least one mismatch recorded.

Behaviour:
- Reset (async assert, sync release): state = IDLE; stim, busy, done, pass, captured, mismatches, first_fail_idx and first_fail_valid = 0. Reset mid-sweep aborts the sweep immediately; no partial results are retained.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start = 1 at edge t: latch expected into an internal register; clear captured, mismatches and first_fail_*; set stim = 0.
  - Enter DRIVE; busy = 1 from cycle t+1.
- DRIVE: hold stim for SETTLE cycles using a settle counter, then go to SAMPLE.
- SAMPLE (one cycle): at its closing edge:
  - captured[stim] <= resp.
  - If resp != latched expected[stim]: increment mismatches; if first_fail_valid == 0, set first_fail_idx = stim and first_fail_valid = 1.
  - If stim == 2**N_IN-1, go to DONE; else stim++ and return to DRIVE.
- DONE (one cycle): done = 1, busy = 0, pass = (mismatches == 0). Then go to IDLE.
- Results hold until the next accepted start; stim holds its last value (2**N_IN-1) in IDLE.
- Timing, with start sampled at edge t:
  - Vector i is driven during cycles t+1+i*(SETTLE+1) .. t+i*(SETTLE+1)+SETTLE+1 and sampled at the end of that range.
  - done is high in cycle t+1+2**N_IN*(SETTLE+1); for defaults, t+49.
- Boundary conditions:
  - start is ignored in DRIVE/SAMPLE/DONE; no restart and no queuing.
  - Changes on expected after the start edge have no effect on the running sweep.
  - Comparison is bitwise; resp is taken as-is, with no synchronizer since the DUT is in the same clock domain.
  - mismatches cannot overflow (N_IN+1 bits hold 2**N_IN).
  - stim increment is the terminal check; no wrap-around occurs within a sweep.

Decomposition:
- Shared include header `lut_sweep_defs.vh`: state encodings (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3) and a localparam for vector count 2**N_IN.
- No sub-module is required: the FSM, settle counter and result registers are one module.
- The bench reuses `lut` as the DUT plus behavioural models for other response functions.

Test Plan:
- N_IN=4, SETTLE=2, resp = ^stim, expected=16'h6996, start at t -> done pulse at t+49; pass=1, captured=16'h6996, mismatches=0, first_fail_valid=0.
- Same DUT, expected=16'h6997 -> pass=0, mismatches=1, first_fail_idx=0, first_fail_valid=1, captured=16'h6996.
- resp tied 0, expected=16'hFFFF -> mismatches=5'd16, first_fail_idx=0, captured=16'h0000, pass=0.
- start re-pulsed at t+10 and expected changed to 16'h0000 at t+12 during scenario 1 -> done still at t+49, pass=1, results identical to scenario 1.
- rst_n low at t+20 -> same cycle busy=0, stim=0, captured=0, mismatches=0. After release, a new start runs a full sweep with done 49 cycles later.
- resp = registered (1-cycle delayed) parity, SETTLE=1 -> pass=1 with done at t+33; same DUT with SETTLE=2 -> pass=1 at t+49.
